// File: rtl/seq_divider_pkg.sv
// Shared definitions for the sequential restoring divider: controller states
// and the iteration counter sizing.
package seq_divider_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int DEFAULT_WIDTH = 8;

  // The counter must be able to represent WIDTH itself.
  function automatic int cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/seq_divider_if.sv
// Start/busy/done request bus between a controller and the divider.
interface seq_divider_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             div_by_zero;

  modport master (
    output start, dividend, divisor,
    input  busy, done, quotient, remainder, div_by_zero
  );

  modport slave (
    input  start, dividend, divisor,
    output busy, done, quotient, remainder, div_by_zero
  );
endinterface

// File: rtl/seq_divider_row.sv
// One restoring step: subtract D from {R, bit} with a ripple-borrow chain and
// keep the difference only when it does not go negative.
module divider_row #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] r_in,
  input  logic             bit_in,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] r_out,
  output logic             q_bit
);

  logic [WIDTH:0]   minuend;
  logic [WIDTH-1:0] diff;
  logic [WIDTH:0]   borrow;

  assign minuend   = {r_in, bit_in};
  assign borrow[0] = 1'b0;

  generate
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_sub
      assign diff[gi]       = minuend[gi] ^ d[gi] ^ borrow[gi];
      assign borrow[gi+1]   = (~minuend[gi] & d[gi]) |
                              (~(minuend[gi] ^ d[gi]) & borrow[gi]);
    end
  endgenerate

  // The divisor's top bit is zero, so a set minuend MSB absorbs any borrow.
  assign q_bit = minuend[WIDTH] | ~borrow[WIDTH];
  assign r_out = q_bit ? diff : minuend[WIDTH-1:0];

endmodule

// File: rtl/seq_divider.sv
// Sequential unsigned restoring divider: one quotient bit per clock through a
// single shared divider_row, with result registers held between completions.
module seq_divider
  import seq_divider_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input logic        clk,
  input logic        rst_n,
  seq_divider_if.slave bus
);

  localparam int             CW   = cnt_width(WIDTH);
  localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] q_reg, q_next;
  logic [WIDTH-1:0] d_reg, d_next;
  logic [WIDTH-1:0] r_reg, r_next;
  logic [CW-1:0]    cnt_reg, cnt_next;
  logic [WIDTH-1:0] quot_reg, quot_next;
  logic [WIDTH-1:0] rem_reg, rem_next;
  logic             dbz_reg, dbz_next;

  logic [WIDTH-1:0] row_r;
  logic             row_q;

  divider_row #(.WIDTH(WIDTH)) u_row (
    .r_in  (r_reg),
    .bit_in(q_reg[WIDTH-1]),
    .d     (d_reg),
    .r_out (row_r),
    .q_bit (row_q)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      q_reg     <= '0;
      d_reg     <= '0;
      r_reg     <= '0;
      cnt_reg   <= '0;
      quot_reg  <= '0;
      rem_reg   <= '0;
      dbz_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      q_reg     <= q_next;
      d_reg     <= d_next;
      r_reg     <= r_next;
      cnt_reg   <= cnt_next;
      quot_reg  <= quot_next;
      rem_reg   <= rem_next;
      dbz_reg   <= dbz_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    q_next     = q_reg;
    d_next     = d_reg;
    r_next     = r_reg;
    cnt_next   = cnt_reg;
    quot_next  = quot_reg;
    rem_next   = rem_reg;
    dbz_next   = dbz_reg;
    case (state_reg)
      IDLE, DONE: begin
        if (bus.start) begin
          q_next   = bus.dividend;
          d_next   = bus.divisor;
          r_next   = '0;
          cnt_next = '0;
          if (bus.divisor != '0) begin
            state_next = RUN;
          end else begin
            // Divide by zero finishes immediately with a saturated quotient.
            state_next = DONE;
            quot_next  = '1;
            rem_next   = bus.dividend;
            dbz_next   = 1'b1;
          end
        end else begin
          state_next = IDLE;
        end
      end
      RUN: begin
        r_next   = row_r;
        q_next   = {q_reg[WIDTH-2:0], row_q};
        cnt_next = cnt_reg + CW'(1);
        if (cnt_reg == LAST) begin
          state_next = DONE;
          quot_next  = {q_reg[WIDTH-2:0], row_q};
          rem_next   = row_r;
          dbz_next   = 1'b0;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign bus.busy        = (state_reg == RUN);
  assign bus.done        = (state_reg == DONE);
  assign bus.quotient    = quot_reg;
  assign bus.remainder   = rem_reg;
  assign bus.div_by_zero = dbz_reg;

endmodule
